// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES tables, byte transforms and core FSM encoding
// Provides: BLOCK_W, NR_OF(nk), S-box/inverse S-box, xtime/gmul helpers,
//           (Inv)SubBytes, (Inv)ShiftRows, (Inv)MixColumns on [0:127] blocks
//           (byte i = bits [8*i +: 8], column-major state), FSM state enum.
package aes_pkg;

   localparam int BLOCK_W = 128;

   localparam logic [7:0] XTIME_POLY = 8'h1b;
   localparam logic [7:0] GF_9 = 8'h09;
   localparam logic [7:0] GF_B = 8'h0b;
   localparam logic [7:0] GF_D = 8'h0d;
   localparam logic [7:0] GF_E = 8'h0e;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   typedef enum logic [1:0] {FSM_IDLE = S_IDLE, FSM_ROUND = S_ROUND, FSM_DONE = S_DONE} aes_fsm_e;

   typedef logic [0:BLOCK_W-1] aes_blk_t;

   function automatic int NR_OF(input int nk);
      return nk + 6;
   endfunction

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
   endfunction

   // Multiplier is always a constant at the call sites, so this folds to a few XORs.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic aes_blk_t sub_bytes(input aes_blk_t s);
      aes_blk_t o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
      return o;
   endfunction

   function automatic aes_blk_t inv_sub_bytes(input aes_blk_t s);
      aes_blk_t o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
      return o;
   endfunction

   // Byte i sits at row i%4, column i/4; row r rotates left (or right) by r columns.
   function automatic aes_blk_t shift_rows(input aes_blk_t s);
      aes_blk_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
      return o;
   endfunction

   function automatic aes_blk_t inv_shift_rows(input aes_blk_t s);
      aes_blk_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) o[8*(r+4*c) +: 8] = s[8*(r+4*((c+4-r)%4)) +: 8];
      return o;
   endfunction

   function automatic aes_blk_t mix_columns(input aes_blk_t s);
      aes_blk_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
         o[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic aes_blk_t inv_mix_columns(input aes_blk_t s);
      aes_blk_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
         o[32*c    +: 8] = gmul(a0, GF_E) ^ gmul(a1, GF_B) ^ gmul(a2, GF_D) ^ gmul(a3, GF_9);
         o[32*c+8  +: 8] = gmul(a0, GF_9) ^ gmul(a1, GF_E) ^ gmul(a2, GF_B) ^ gmul(a3, GF_D);
         o[32*c+16 +: 8] = gmul(a0, GF_D) ^ gmul(a1, GF_9) ^ gmul(a2, GF_E) ^ gmul(a3, GF_B);
         o[32*c+24 +: 8] = gmul(a0, GF_B) ^ gmul(a1, GF_D) ^ gmul(a2, GF_9) ^ gmul(a3, GF_E);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_core_iter_inv_round.sv
// rtl/aes_core_iter_inv_round.sv - one combinational AES decryption round
// Ports: state - current block; rk - round key; last - final round (no InvMixColumns);
//        out - InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk), or without the mix when last.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [0:BLOCK_W-1] state,
   input  logic [0:BLOCK_W-1] rk,
   input  logic               last,
   output logic [0:BLOCK_W-1] out
);

   aes_blk_t keyed;

   assign keyed = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
   assign out   = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_core_iter.sv
// rtl/aes_core_iter.sv - iterative AES-128/192/256 core, one round per clock, enc/dec
// Ports: clk; reset (async, active-high); in_valid/in_ready/mode/data_in offer a block
//        (mode 0 = encrypt, 1 = decrypt); keySchedule holds round key r at bits [128*r +: 128]
//        and must stay stable until out_valid; out_valid/out_ready/data_out return the result;
//        busy is high while rounds are running.
module aes_core_iter
   import aes_pkg::*;
#(
   parameter int nk = 4,
   parameter int nr = nk + 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       mode,
   input  logic [0:BLOCK_W-1]         data_in,
   input  logic [0:BLOCK_W*(nr+1)-1]  keySchedule,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [0:BLOCK_W-1]         data_out,
   output logic                       busy
);

   localparam int            CW   = $clog2(nr + 1);
   localparam logic [CW-1:0] NR_C = CW'(nr);

   if (nr != NR_OF(nk) || !(nk == 4 || nk == 6 || nk == 8)) begin : g_bad_params
      $error("aes_core_iter: nk must be 4, 6 or 8 and nr must equal nk+6");
   end

   aes_fsm_e      fsm;
   logic [CW-1:0] cnt;
   logic [CW-1:0] key_idx;
   logic          mode_q;
   logic          accept;
   logic          last;
   aes_blk_t      state;
   aes_blk_t      rk_sel;
   aes_blk_t      enc_sr;
   aes_blk_t      enc_out;
   aes_blk_t      dec_out;
   aes_blk_t      round_out;

   // A finished block can be replaced in the same cycle it is taken downstream.
   assign in_ready = !reset && (fsm == FSM_IDLE || (fsm == FSM_DONE && out_ready));
   assign accept   = in_valid && in_ready;
   assign busy     = (fsm == FSM_ROUND);
   assign last     = (cnt == NR_C);
   assign data_out = out_valid ? state : '0;

   // One shared key mux: the whitening key at accept, then the per-round key.
   // Decryption walks the schedule backwards from rk[nr].
   always_comb begin
      key_idx = '0;
      if (fsm == FSM_ROUND) key_idx = mode_q ? NR_C - cnt : cnt;
      else if (mode)        key_idx = NR_C;
      rk_sel = '0;
      for (int r = 0; r <= nr; r++)
         if (key_idx == CW'(r)) rk_sel = keySchedule[BLOCK_W*r +: BLOCK_W];
   end

   assign enc_sr    = shift_rows(sub_bytes(state));
   assign enc_out   = (last ? enc_sr : mix_columns(enc_sr)) ^ rk_sel;
   assign round_out = mode_q ? dec_out : enc_out;

   aes_inv_round u_inv_round (
      .state (state),
      .rk    (rk_sel),
      .last  (last),
      .out   (dec_out)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm       <= FSM_IDLE;
         cnt       <= '0;
         state     <= '0;
         mode_q    <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         state     <= data_in ^ rk_sel;
         mode_q    <= mode;
         cnt       <= CW'(1);
         fsm       <= FSM_ROUND;
         out_valid <= 1'b0;
      end else begin
         case (fsm)
            FSM_ROUND: begin
               state <= round_out;
               if (last) begin
                  fsm       <= FSM_DONE;
                  out_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FSM_DONE: begin
               if (out_ready) begin
                  fsm       <= FSM_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_core_iter.sv
// tb/tb_aes_core_iter.sv - self-checking bench for aes_core_iter (nk = 4, 6, 8 instances)
module tb_aes_core_iter;
   import aes_pkg::*;

   typedef struct {
      int          inst;
      logic        mode;
      logic [0:127] din;
      logic [0:127] exp;
      logic [0:255] key;
   } vec_t;

   typedef struct {
      int          inst;
      logic [0:127] exp;
   } sb_t;

   localparam logic [0:127] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [0:127] CT4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [0:127] CT6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [0:127] CT8  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [0:127] TPT  = 128'h54776f204f6e65204e696e652054776f;
   localparam logic [0:127] TCT  = 128'h29c3505f571420f6402299b31a02d73a;
   localparam logic [0:255] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [0:255] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [0:255] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [0:255] KTWO = {128'h5468617473206d79204b756e67204675, 128'h0};

   logic          clk;
   logic          reset;
   logic [2:0]    in_valid, in_ready, mode, out_valid, out_ready, busy;
   logic [0:127]  data_in  [3];
   logic [0:127]  data_out [3];
   logic [0:1919] ks       [3];
   logic [0:1919] ks_hold  [3];

   int   n_vec = 0;
   int   n_fail = 0;
   int   idx;
   sb_t  sbq[$];
   vec_t vecs [8];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_core_iter #(.nk(4 + 2*g)) u_dut (
         .clk         (clk),
         .reset       (reset),
         .in_valid    (in_valid[g]),
         .in_ready    (in_ready[g]),
         .mode        (mode[g]),
         .data_in     (data_in[g]),
         .keySchedule (ks[g][0:128*(4+2*g+7)-1]),
         .out_valid   (out_valid[g]),
         .out_ready   (out_ready[g]),
         .data_out    (data_out[g]),
         .busy        (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   function automatic int nk_of(input int k);
      return 4 + 2*k;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
   endfunction

   function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [0:1919] o;
      int            tot;
      tot = 4 * (nk + 7);
      rc  = 8'h01;
      o   = '0;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
      for (int i = nk; i < tot; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < tot; i++) o[32*i +: 32] = w[i];
      return o;
   endfunction

   task automatic chk(input logic [127:0] act, input logic [127:0] exp, input string nm);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until out_valid; latency includes the accept edge itself.
   task automatic wait_out(input int k, input int already, input string nm);
      int edges;
      edges = already;
      while (!out_valid[k] && edges < 40) begin
         tick();
         edges++;
         if (edges == already + 1) chk(busy[k], 1, {nm, "_busy"});
      end
      chk(edges + 1, nk_of(k) + 7, {nm, "_latency"});
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int k;
      k = v.inst;
      ks[k]        = expand(v.key, nk_of(k));
      data_in[k]   = v.din;
      mode[k]      = v.mode;
      in_valid[k]  = 1'b1;
      out_ready[k] = 1'b1;
      sbq.push_back('{k, v.exp});
      @(negedge clk);
      chk(in_ready[k], 1, {nm, "_in_ready"});
      tick();
      in_valid[k] = 1'b0;
      wait_out(k, 0, nm);
      tick();
      chk(out_valid[k], 0, {nm, "_consumed"});
   endtask

   // Scoreboard and key-stability monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            if (in_valid[k] && in_ready[k]) ks_hold[k] = ks[k];
            if (busy[k])
               assert (ks[k] === ks_hold[k])
               else begin
                  n_fail++;
                  $display("FAIL ks_stable inst %0d: changed=1 required=0", k);
               end
            if (out_valid[k] && out_ready[k]) begin
               idx = -1;
               for (int j = 0; j < sbq.size(); j++)
                  if (idx < 0 && sbq[j].inst == k) idx = j;
               n_vec++;
               if (idx < 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected inst %0d: got %h required no output", k, data_out[k]);
               end else begin
                  if (data_out[k] !== sbq[idx].exp) begin
                     n_fail++;
                     $display("FAIL sb_data inst %0d: got %h required %h", k, data_out[k], sbq[idx].exp);
                  end
                  sbq.delete(idx);
               end
            end
         end
      end
   end

   initial begin
      int hold_err, rdy_err;
      vecs[0] = '{0, 1'b0, PT,  CT4, K128};
      vecs[1] = '{0, 1'b1, CT4, PT,  K128};
      vecs[2] = '{0, 1'b0, TPT, TCT, KTWO};
      vecs[3] = '{0, 1'b1, TCT, TPT, KTWO};
      vecs[4] = '{1, 1'b0, PT,  CT6, K192};
      vecs[5] = '{1, 1'b1, CT6, PT,  K192};
      vecs[6] = '{2, 1'b0, PT,  CT8, K256};
      vecs[7] = '{2, 1'b1, CT8, PT,  K256};

      reset = 1'b1;
      in_valid = '0; out_ready = '0; mode = '0;
      for (int k = 0; k < 3; k++) begin
         data_in[k] = '0; ks[k] = '0; ks_hold[k] = '0;
      end

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk(in_ready[k], 0, $sformatf("rst_in_ready%0d", k));
         chk(out_valid[k], 0, $sformatf("rst_out_valid%0d", k));
         chk(busy[k], 0, $sformatf("rst_busy%0d", k));
         chk(data_out[k], 0, $sformatf("rst_data_out%0d", k));
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk(in_ready[k], 1, $sformatf("post_rst_in_ready%0d", k));
      tick();

      // Table-driven known-answer vectors for all three key lengths
      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Backpressure: hold result 20 cycles, then consume and accept on one edge
      ks[0] = expand(K128, 4);
      data_in[0] = PT; mode[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
      sbq.push_back('{0, CT4});
      tick();
      in_valid[0] = 1'b0;
      wait_out(0, 0, "bp_a");
      hold_err = 0; rdy_err = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (data_out[0] !== CT4 || !out_valid[0]) hold_err++;
         if (in_ready[0] !== 1'b0) rdy_err++;
      end
      chk(hold_err, 0, "bp_hold_data");
      chk(rdy_err, 0, "bp_hold_in_ready");
      out_ready[0] = 1'b1; in_valid[0] = 1'b1; mode[0] = 1'b1; data_in[0] = CT4;
      sbq.push_back('{0, PT});
      @(negedge clk);
      chk(in_ready[0], 1, "bp_same_edge_ready");
      tick();
      in_valid[0] = 1'b0;
      chk(out_valid[0], 0, "bp_valid_cleared");
      wait_out(0, 0, "bp_b");
      tick();

      // Asynchronous reset during round 5 discards the block
      data_in[0] = PT; mode[0] = 1'b0; in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      repeat (4) tick();
      chk(busy[0], 1, "rst_mid_busy_before");
      #2 reset = 1'b1;
      #1;
      chk(out_valid[0], 0, "rst_mid_out_valid");
      chk(data_out[0], 0, "rst_mid_data_out");
      chk(busy[0], 0, "rst_mid_busy");
      chk(in_ready[0], 0, "rst_mid_in_ready");
      tick();
      reset = 1'b0;
      tick();
      run_vec(vecs[2], "after_rst");

      // in_valid pulses and mode toggles while busy are ignored
      ks[0] = expand(K128, 4);
      data_in[0] = PT; mode[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
      sbq.push_back('{0, CT4});
      tick();
      rdy_err = 0;
      for (int i = 0; i < 6; i++) begin
         in_valid[0] = (i % 2 == 0);
         mode[0]     = ~mode[0];
         data_in[0]  = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         if (in_ready[0] !== 1'b0) rdy_err++;
         tick();
      end
      in_valid[0] = 1'b0;
      chk(rdy_err, 0, "busy_in_ready");
      wait_out(0, 6, "busy_ign");
      tick();
      chk(out_valid[0], 0, "busy_ign_consumed");

      repeat (2) tick();
      chk(sbq.size(), 0, "sb_drain");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
